// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver and the
// game logic that feeds it. Patterns are active low, bit order a..g,dp = [7..0].
package sseg_pkg;

  // All cathodes released.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit positions of each segment inside an 8-bit pattern.
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Decimal glyphs (active low, dp off).
  localparam logic [7:0] GLYPH_0 = 8'b00000011;
  localparam logic [7:0] GLYPH_1 = 8'b10011111;
  localparam logic [7:0] GLYPH_2 = 8'b00100101;
  localparam logic [7:0] GLYPH_3 = 8'b00001101;
  localparam logic [7:0] GLYPH_4 = 8'b10011001;
  localparam logic [7:0] GLYPH_5 = 8'b01001001;
  localparam logic [7:0] GLYPH_6 = 8'b01000001;
  localparam logic [7:0] GLYPH_7 = 8'b00011111;
  localparam logic [7:0] GLYPH_8 = 8'b00000001;
  localparam logic [7:0] GLYPH_9 = 8'b00001001;

  // Board-cell encoding used by the game-state logic.
  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'd0,
    CELL_OCCUPIED = 2'd1,
    CELL_FLASHING = 2'd2
  } cell_t;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Map a decimal value to its glyph; anything above 9 shows nothing.
  function automatic logic [7:0] digit_glyph(input logic [3:0] value);
    case (value)
      4'd0:    digit_glyph = GLYPH_0;
      4'd1:    digit_glyph = GLYPH_1;
      4'd2:    digit_glyph = GLYPH_2;
      4'd3:    digit_glyph = GLYPH_3;
      4'd4:    digit_glyph = GLYPH_4;
      4'd5:    digit_glyph = GLYPH_5;
      4'd6:    digit_glyph = GLYPH_6;
      4'd7:    digit_glyph = GLYPH_7;
      4'd8:    digit_glyph = GLYPH_8;
      4'd9:    digit_glyph = GLYPH_9;
      default: digit_glyph = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sseg_scan_mux_tick_gen.sv
// One-cycle enable pulse every DIV clock cycles. Used instead of a derived
// clock so everything downstream stays on the single system clock.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pulse on the final count; with DIV=1 this is high every cycle.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed driver for an N-digit active-low common-anode display.
// Each digit slot is a short dead time (BLANK) followed by DRIVE. The digit
// pattern and its mask bits are captured once at DRIVE start so a change from
// upstream never tears a digit mid-slot. Blink phase changes only at slot
// boundaries. Outputs are computed from next-state values and registered so
// they line up exactly with the state register.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 2200,
  parameter int BLANK_CYC  = 16,
  parameter int BLINK_DIV  = 10000000,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   DISP_EN,
  output logic [7:0]              SEGMENTS,
  output logic [DW-1:0]           digit_idx,
  output logic                    frame_done,
  output logic                    blink_phase
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] LAST_SLOT   = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] LAST_BLANK  = SW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [SW-1:0] DRIVE_FIRST = SW'(BLANK_CYC);
  localparam logic [DW-1:0] LAST_DIGIT  = DW'(NUM_DIGITS - 1);
  localparam scan_state_t   SLOT_ENTRY  = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

  scan_state_t           state;
  scan_state_t           state_next;
  logic [SW-1:0]         slot_cnt;
  logic [SW-1:0]         slot_next;
  logic [DW-1:0]         digit_next;
  logic                  slot_start;
  logic                  drive_start;
  logic                  blink_tick;
  logic                  blink_pending;
  logic                  toggle_now;
  logic                  phase_next;
  logic [7:0]            pat_reg;
  logic                  blink_bit_reg;
  logic                  blank_bit_reg;
  logic [7:0]            pat_next;
  logic                  blink_bit_next;
  logic                  blank_bit_next;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] disp_next;
  logic                  frame_next;
  logic [7:0]            digit_pat [NUM_DIGITS];

  tick_gen #(
    .DIV (BLINK_DIV)
  ) u_blink_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (blink_tick)
  );

  // Split the flat pattern bus into one byte per digit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign digit_pat[gi] = seg_data[8*gi +: 8];
  end

  // Next scan position: which state, slot cycle and digit the next cycle is.
  always_comb begin
    state_next = state;
    slot_next  = slot_cnt;
    digit_next = digit_idx;
    slot_start = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      slot_next  = '0;
      digit_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = SLOT_ENTRY;
          slot_next  = '0;
          digit_next = '0;
          slot_start = 1'b1;
        end
        ST_BLANK: begin
          slot_next = slot_cnt + 1'b1;
          if (slot_cnt == LAST_BLANK) begin
            state_next = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (slot_cnt == LAST_SLOT) begin
            state_next = SLOT_ENTRY;
            slot_next  = '0;
            digit_next = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
            slot_start = 1'b1;
          end else begin
            slot_next = slot_cnt + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          slot_next  = '0;
          digit_next = '0;
        end
      endcase
    end
  end

  // Capture point, blink phase and the output values for the next cycle.
  always_comb begin
    drive_start    = (state_next == ST_DRIVE) && (slot_next == DRIVE_FIRST);
    toggle_now     = slot_start && (blink_pending || blink_tick);
    phase_next     = blink_phase ^ toggle_now;
    pat_next       = drive_start ? digit_pat[digit_next]  : pat_reg;
    blink_bit_next = drive_start ? blink_mask[digit_next] : blink_bit_reg;
    blank_bit_next = drive_start ? blank_mask[digit_next] : blank_bit_reg;
    seg_next       = SEG_OFF;
    if ((state_next == ST_DRIVE) && !blank_bit_next && !(blink_bit_next && phase_next)) begin
      seg_next = pat_next;
    end
    frame_next = (state_next == ST_DRIVE) && (digit_next == LAST_DIGIT) &&
                 (slot_next == LAST_SLOT);
  end

  // Anode enables: only the active digit is pulled low, and only in DRIVE.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign disp_next[gi] = !((state_next == ST_DRIVE) && (digit_next == DW'(gi)));
  end

  // Scan state, latched digit data, blink phase and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      slot_cnt      <= '0;
      digit_idx     <= '0;
      blink_phase   <= 1'b0;
      blink_pending <= 1'b0;
      pat_reg       <= SEG_OFF;
      blink_bit_reg <= 1'b0;
      blank_bit_reg <= 1'b0;
      DISP_EN       <= '1;
      SEGMENTS      <= SEG_OFF;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_next;
      slot_cnt      <= slot_next;
      digit_idx     <= digit_next;
      blink_phase   <= phase_next;
      pat_reg       <= pat_next;
      blink_bit_reg <= blink_bit_next;
      blank_bit_reg <= blank_bit_next;
      if (toggle_now) begin
        blink_pending <= 1'b0;
      end else if (blink_tick) begin
        blink_pending <= 1'b1;
      end
      DISP_EN    <= disp_next;
      SEGMENTS   <= seg_next;
      frame_done <= frame_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomised scoreboard bench for sseg_scan_mux. A reference process derives
// the expected display state each cycle from elapsed-time arithmetic (slot
// number, position in slot, blink tick count) and queues it; a monitor pops
// and compares on every falling edge. A second instance with no dead time
// checks that the anodes never all go dark between slots while scanning.
module tb_sseg_scan_mux;
  import sseg_pkg::*;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 64;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          en = 1'b0;
  logic [8*ND-1:0] seg_data = '0;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] blank_mask = '0;

  logic [ND-1:0] disp_en;
  logic [7:0]    segments;
  logic [1:0]    digit_idx;
  logic          frame_done;
  logic          blink_phase;

  logic [ND-1:0] disp_en0;
  logic [7:0]    segments0;
  logic [1:0]    digit_idx0;
  logic          frame_done0;
  logic          blink_phase0;

  sseg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .seg_data(seg_data),
    .blink_mask(blink_mask), .blank_mask(blank_mask),
    .DISP_EN(disp_en), .SEGMENTS(segments), .digit_idx(digit_idx),
    .frame_done(frame_done), .blink_phase(blink_phase)
  );

  sseg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_DIV(BD)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .en(en), .seg_data(seg_data),
    .blink_mask(blink_mask), .blank_mask(blank_mask),
    .DISP_EN(disp_en0), .SEGMENTS(segments0), .digit_idx(digit_idx0),
    .frame_done(frame_done0), .blink_phase(blink_phase0)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ND-1:0] disp;
    logic [7:0]    seg;
    logic [1:0]    idx;
    logic          frame;
    logic          ph;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   model_active = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: time since scan start gives digit and slot position.
  bit          m_active = 1'b0;
  bit          m_phase = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_tick;
  int          m_t = 0;
  int          m_gcnt = 0;
  int          m_digit;
  int          m_pos;
  logic [7:0]  m_pat = 8'hFF;
  bit          m_blink = 1'b0;
  bit          m_blank = 1'b0;
  exp_t        m_e;

  initial begin : model
    forever begin
      @(posedge CLK);
      m_e.disp  = '1;
      m_e.seg   = 8'hFF;
      m_e.idx   = 2'd0;
      m_e.frame = 1'b0;
      if (!RST_N) begin
        m_active  = 1'b0;
        m_phase   = 1'b0;
        m_pending = 1'b0;
        m_gcnt    = 0;
        m_t       = 0;
      end else begin
        m_tick    = (m_gcnt % BD) == BD - 1;
        m_gcnt++;
        m_pending = m_pending | m_tick;
        if (!en) begin
          m_active = 1'b0;
        end else begin
          if (!m_active) begin
            m_active = 1'b1;
            m_t = 0;
          end else begin
            m_t = (m_t + 1) % (ND * SD);
          end
          m_pos   = m_t % SD;
          m_digit = m_t / SD;
          if (m_pos == 0 && m_pending) begin
            m_phase   = ~m_phase;
            m_pending = 1'b0;
          end
          if (m_pos == BC) begin
            m_pat   = seg_data[8*m_digit +: 8];
            m_blink = blink_mask[m_digit];
            m_blank = blank_mask[m_digit];
          end
          if (m_pos >= BC) begin
            m_e.disp = ~(4'(1) << m_digit);
            if (!m_blank && !(m_blink && m_phase)) m_e.seg = m_pat;
          end
          m_e.idx   = 2'(m_digit);
          m_e.frame = (m_digit == ND - 1) && (m_pos == SD - 1);
        end
      end
      m_e.ph = m_phase;
      model_active = m_active;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare both instances against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard_empty: got no expectation, expected one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("disp_en", 8'(disp_en), 8'(e.disp));
        check("segments", segments, e.seg);
        check("digit_idx", 8'(digit_idx), 8'(e.idx));
        check("frame_done", 8'(frame_done), 8'(e.frame));
        check("blink_phase", 8'(blink_phase), 8'(e.ph));
        check("nb_digit_idx", 8'(digit_idx0), 8'(e.idx));
        check("nb_frame_done", 8'(frame_done0), 8'(e.frame));
        check("nb_blink_phase", 8'(blink_phase0), 8'(e.ph));
        if (model_active) begin
          compared++;
          if (disp_en0 === '1 || $isunknown(disp_en0)) begin
            mismatched++;
            $display("FAIL nb_anode_gap: got %b, expected one digit low at %0t", disp_en0, $time);
          end
        end else begin
          check("nb_segments_off", segments0, 8'hFF);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Bounded wait until the given digit is being driven.
  task automatic wait_drive(input int d);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (digit_idx == 2'(d) && disp_en != '1) break;
    end
    if (n == 200) begin
      compared++;
      mismatched++;
      $display("FAIL wait_drive: got timeout, expected digit %0d driving", d);
    end
  endtask

  initial begin : stim
    run(3);
    seg_data = {GLYPH_2, GLYPH_1, 8'h00, 8'hFE};
    en = 1'b1;
    #1 RST_N = 1'b1;
    run(70);

    // Pattern change mid-slot must wait for the next slot of that digit.
    wait_drive(0);
    run(2);
    seg_data[7:0] = 8'($urandom);
    run(70);

    // Blinking digit 0.
    blink_mask = 4'b0001;
    run(300);
    blink_mask = 4'b0000;

    // Blanked digit 3.
    blank_mask = 4'b1000;
    run(40);
    blank_mask = 4'b0000;

    // Disable mid-slot of digit 2, then restart.
    wait_drive(2);
    run(1);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(40);

    // Asynchronous reset mid-DRIVE.
    wait_drive(1);
    #1 RST_N = 1'b0;
    #1;
    check("async_disp_en", 8'(disp_en), 8'h0F);
    check("async_segments", segments, 8'hFF);
    check("async_digit_idx", 8'(digit_idx), 8'h00);
    check("async_frame_done", 8'(frame_done), 8'h00);
    check("async_blink_phase", 8'(blink_phase), 8'h00);
    run(2);
    #1 RST_N = 1'b1;
    run(70);

    // Randomised traffic.
    for (int i = 0; i < 25; i++) begin
      seg_data   = $urandom;
      blink_mask = 4'($urandom);
      blank_mask = 4'($urandom);
      en         = ($urandom_range(0, 7) != 0);
      run($urandom_range(3, 60));
    end
    en = 1'b1;
    run(100);

    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
